// File: rtl/memory_arbiter_if.sv
// Bus bundle between the fetch stage, the memory stage, the arbiter and MEMORY.
// Handshake: a requester raises *_request with stable operands and holds them
// until its one-cycle *_ready pulse; the pulse is the only completion signal.
// arb_state exposes the arbiter FSM state for debug and checkers.
interface memory_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     fetch_request;
    logic [ADDRESS_WIDTH-1:0] fetch_address;
    logic                     fetch_ready;
    logic [DATA_WIDTH-1:0]    fetch_data;

    logic                     data_request;
    logic                     data_write_enable;
    logic [ADDRESS_WIDTH-1:0] data_address;
    logic [DATA_WIDTH-1:0]    data_write_data;
    logic                     data_ready;
    logic [DATA_WIDTH-1:0]    data_read_data;

    logic                     memory_enable;
    logic [ADDRESS_WIDTH-1:0] memory_address;
    logic                     memory_write_enable;
    logic [DATA_WIDTH-1:0]    memory_write_data;
    logic [DATA_WIDTH-1:0]    memory_read_data;

    logic [1:0]               arb_state;

    // Arbiter side.
    modport slave (
        input  fetch_request, fetch_address,
        output fetch_ready, fetch_data,
        input  data_request, data_write_enable, data_address, data_write_data,
        output data_ready, data_read_data,
        output memory_enable, memory_address, memory_write_enable, memory_write_data,
        input  memory_read_data,
        output arb_state
    );

    // Requester / memory / environment side.
    modport master (
        output fetch_request, fetch_address,
        input  fetch_ready, fetch_data,
        output data_request, data_write_enable, data_address, data_write_data,
        input  data_ready, data_read_data,
        input  memory_enable, memory_address, memory_write_enable, memory_write_data,
        output memory_read_data,
        input  arb_state
    );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch stage
// (read-only) and the memory stage (load/store). One access in flight at a
// time: IDLE (arbitrate) -> ACCESS (MEM_LATENCY cycles) -> DONE (ready pulse).
module memory_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_LATENCY   = 1
) (
    input logic              clk,
    input logic              reset,
    memory_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] COUNT_START = 4'(MEM_LATENCY - 1);

    state_t                   state;
    state_t                   state_next;
    logic [3:0]               counter;
    logic                     last_grant_data;   // 1: data won the last arbitration
    logic                     grant_data;        // winner of the access in flight
    logic                     access_write;      // access in flight is a store
    logic                     any_request;
    logic                     pick_data;

    logic [ADDRESS_WIDTH-1:0] memory_address_q;
    logic [DATA_WIDTH-1:0]    memory_write_data_q;
    logic [DATA_WIDTH-1:0]    fetch_data_q;
    logic [DATA_WIDTH-1:0]    data_read_data_q;

    // Arbitration: a lone request wins; on a tie the side that did not win last time wins.
    always_comb begin
        any_request = bus.fetch_request | bus.data_request;
        pick_data   = bus.data_request & (~bus.fetch_request | ~last_grant_data);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_request) state_next = ACCESS;
            ACCESS:  if (counter == 4'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Access datapath: latch the winner's operands, count latency, capture read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter             <= 4'd0;
            last_grant_data     <= 1'b0;
            grant_data          <= 1'b0;
            access_write        <= 1'b0;
            memory_address_q    <= '0;
            memory_write_data_q <= '0;
            fetch_data_q        <= '0;
            data_read_data_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_request) begin
                        memory_address_q    <= pick_data ? bus.data_address : bus.fetch_address;
                        memory_write_data_q <= pick_data ? bus.data_write_data : '0;
                        access_write        <= pick_data & bus.data_write_enable;
                        grant_data          <= pick_data;
                        last_grant_data     <= pick_data;
                        counter             <= COUNT_START;
                    end
                end
                ACCESS: begin
                    if (counter != 4'd0) begin
                        counter <= counter - 4'd1;
                    end else if (!access_write) begin
                        if (grant_data) begin
                            data_read_data_q <= bus.memory_read_data;
                        end else begin
                            fetch_data_q <= bus.memory_read_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state: enable and strobe track ACCESS, ready pulses in DONE.
    always_comb begin
        bus.memory_enable       = (state == ACCESS);
        bus.memory_write_enable = (state == ACCESS) && (counter == 4'd0) && access_write;
        bus.fetch_ready         = (state == DONE) && !grant_data;
        bus.data_ready          = (state == DONE) && grant_data;
        bus.arb_state           = state;
    end

    assign bus.memory_address    = memory_address_q;
    assign bus.memory_write_data = memory_write_data_q;
    assign bus.fetch_data        = fetch_data_q;
    assign bus.data_read_data    = data_read_data_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with MEM_LATENCY=2 and a word-addressed
// memory model preloaded with word[i] = 0x1000 + i.
module tb_memory_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    memory_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    memory_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Memory model: loaded on the first clock edge, written on strobe.
    logic [DW-1:0] mem [0:255];
    bit            mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h1000 + 32'(i);
            mem_loaded <= 1'b1;
        end else if (bus.memory_enable && bus.memory_write_enable) begin
            mem[bus.memory_address[7:0]] <= bus.memory_write_data;
        end
    end

    assign bus.memory_read_data = mem_loaded ? mem[bus.memory_address[7:0]] : '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_fetch_ready"}, 64'(bus.fetch_ready), 0);
        check({pfx, "_data_ready"}, 64'(bus.data_ready), 0);
        check({pfx, "_fetch_data"}, 64'(bus.fetch_data), 0);
        check({pfx, "_data_read_data"}, 64'(bus.data_read_data), 0);
        check({pfx, "_mem_en"}, 64'(bus.memory_enable), 0);
        check({pfx, "_mem_addr"}, 64'(bus.memory_address), 0);
        check({pfx, "_mem_we"}, 64'(bus.memory_write_enable), 0);
        check({pfx, "_mem_wdata"}, 64'(bus.memory_write_data), 0);
    endtask

    task automatic drive_idle();
        bus.fetch_request     = 1'b0;
        bus.fetch_address     = '0;
        bus.data_request      = 1'b0;
        bus.data_write_enable = 1'b0;
        bus.data_address      = '0;
        bus.data_write_data   = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Advance one cycle and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for a ready pulse of one requester; cyc = edges taken, 0 on timeout.
    task automatic wait_ready(input bit want_data, input int max_cycles, output int cyc);
        cyc = 0;
        for (int i = 1; i <= max_cycles; i++) begin
            step();
            if ((want_data && bus.data_ready) || (!want_data && bus.fetch_ready)) begin
                cyc = i;
                check("ready_exclusive", 64'(bus.data_ready & bus.fetch_ready), 0);
                return;
            end
        end
        check("ready_timeout", 0, 1);
    endtask

    initial begin
        int  cyc;
        int  we_cnt;
        int  ready_cnt;
        int  seen;
        bit  prev_ready;
        bit  exp_data;

        n_tests = 0;
        n_fail  = 0;
        drive_idle();
        reset = 1'b1;
        #1;
        check_all_zero("reset");
        do_reset();

        // Single fetch with latency 2.
        bus.fetch_request = 1'b1;
        bus.fetch_address = 32'h10;
        step();
        check("f1_en_a", 64'(bus.memory_enable), 1);
        check("f1_addr", 64'(bus.memory_address), 64'h10);
        check("f1_ready_early", 64'(bus.fetch_ready), 0);
        step();
        check("f1_en_b", 64'(bus.memory_enable), 1);
        step();
        check("f1_en_off", 64'(bus.memory_enable), 0);
        check("f1_ready", 64'(bus.fetch_ready), 1);
        check("f1_data", 64'(bus.fetch_data), 64'h1010);
        bus.fetch_request = 1'b0;
        step();
        check("f1_ready_pulse", 64'(bus.fetch_ready), 0);
        check("f1_idle", 64'(bus.arb_state), 0);

        // Tie after reset: data first, fetch four cycles later.
        do_reset();
        bus.fetch_request = 1'b1;
        bus.fetch_address = 32'h4;
        bus.data_request  = 1'b1;
        bus.data_address  = 32'h8;
        wait_ready(1'b1, 10, cyc);
        check("tie_data_cyc", 64'(cyc), 3);
        check("tie_data_val", 64'(bus.data_read_data), 64'h1008);
        check("tie_fetch_quiet", 64'(bus.fetch_ready), 0);
        bus.data_request = 1'b0;
        wait_ready(1'b0, 10, cyc);
        check("tie_fetch_cyc", 64'(cyc), 4);
        check("tie_fetch_val", 64'(bus.fetch_data), 64'h1004);
        bus.fetch_request = 1'b0;
        step();

        // Store then load the same word.
        bus.data_request      = 1'b1;
        bus.data_write_enable = 1'b1;
        bus.data_address      = 32'h20;
        bus.data_write_data   = 32'hDEADBEEF;
        we_cnt = 0;
        seen   = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            step();
            if (bus.memory_write_enable) begin
                we_cnt++;
                check("st_we_addr", 64'(bus.memory_address), 64'h20);
                check("st_we_data", 64'(bus.memory_write_data), 64'hDEADBEEF);
            end
            if (bus.data_ready) seen = i + 1;
        end
        check("st_ready_cyc", 64'(seen), 3);
        check("st_we_count", 64'(we_cnt), 1);
        check("st_mem", 64'(mem[8'h20]), 64'hDEADBEEF);
        check("st_rdata_held", 64'(bus.data_read_data), 64'h1008);
        bus.data_request      = 1'b0;
        bus.data_write_enable = 1'b0;
        step();
        bus.data_request = 1'b1;
        wait_ready(1'b1, 10, cyc);
        check("ld_cyc", 64'(cyc), 3);
        check("ld_val", 64'(bus.data_read_data), 64'hDEADBEEF);
        check("ld_fetch_held", 64'(bus.fetch_data), 64'h1004);
        bus.data_request = 1'b0;
        step();

        // Both held continuously: six alternating grants starting with data.
        do_reset();
        bus.fetch_request = 1'b1;
        bus.fetch_address = 32'h1;
        bus.data_request  = 1'b1;
        bus.data_address  = 32'h2;
        exp_data   = 1'b1;
        ready_cnt  = 0;
        prev_ready = 1'b0;
        for (int i = 0; i < 40 && ready_cnt < 6; i++) begin
            step();
            if (bus.fetch_ready || bus.data_ready) begin
                check("rr_single_pulse", 64'(prev_ready), 0);
                check("rr_order", 64'({bus.data_ready, bus.fetch_ready}),
                      exp_data ? 64'b10 : 64'b01);
                if (exp_data) check("rr_dval", 64'(bus.data_read_data), 64'h1002);
                else          check("rr_fval", 64'(bus.fetch_data), 64'h1001);
                exp_data = ~exp_data;
                ready_cnt++;
                prev_ready = 1'b1;
            end else begin
                prev_ready = 1'b0;
            end
        end
        check("rr_count", 64'(ready_cnt), 6);
        drive_idle();
        repeat (4) step();

        // Reset in the first ACCESS cycle of a store aborts it.
        bus.data_request      = 1'b1;
        bus.data_write_enable = 1'b1;
        bus.data_address      = 32'h30;
        bus.data_write_data   = 32'h12345678;
        step();
        check("abort_in_access", 64'(bus.arb_state), 1);
        reset = 1'b1;
        drive_idle();
        #1;
        check_all_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.fetch_ready || bus.data_ready || bus.memory_write_enable) seen++;
        end
        check("abort_quiet", 64'(seen), 0);
        check("abort_mem", 64'(mem[8'h30]), 64'h1030);
        bus.fetch_request = 1'b1;
        bus.fetch_address = 32'h5;
        wait_ready(1'b0, 10, cyc);
        check("abort_next_cyc", 64'(cyc), 3);
        check("abort_next_val", 64'(bus.fetch_data), 64'h1005);
        bus.fetch_request = 1'b0;
        step();

        // Fetch dropped one cycle after grant still completes.
        bus.fetch_request = 1'b1;
        bus.fetch_address = 32'h7;
        step();
        check("drop_granted", 64'(bus.memory_enable), 1);
        step();
        bus.fetch_request = 1'b0;
        step();
        check("drop_ready", 64'(bus.fetch_ready), 1);
        check("drop_val", 64'(bus.fetch_data), 64'h1007);
        step();
        step();
        check("drop_no_grant", 64'(bus.memory_enable), 0);
        check("drop_idle", 64'(bus.arb_state), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single-port instruction/data MEMORY between the fetch stage (read-only) and the memory stage (load/store).
- Arbitrates between the two requesters and sequences each memory access over MEM_LATENCY cycles.
- Returns read data to the winning requester with a one-cycle ready pulse.
- Sits between FETCH_STAGE / memory stage and MEMORY, replacing the direct address/data wiring.

Parameters:
- ADDRESS_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all data buses.
- MEM_LATENCY, 1, number of cycles the address is held on memory before read data is sampled. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- fetch_request  input  1  fetch stage requests an instruction read.
- fetch_address  input  ADDRESS_WIDTH  instruction address.
- fetch_ready  output  1  one-cycle pulse: fetch_data is valid.
- fetch_data  output  DATA_WIDTH  registered instruction word.
- data_request  input  1  memory stage requests an access.
- data_write_enable  input  1  1 = store, 0 = load; sampled with data_request.
- data_address  input  ADDRESS_WIDTH  load/store address.
- data_write_data  input  DATA_WIDTH  store data.
- data_ready  output  1  one-cycle pulse: access complete (load data valid).
- data_read_data  output  DATA_WIDTH  registered load data.
- memory_enable  output  1  high while an access is in progress.
- memory_address  output  ADDRESS_WIDTH  registered address to MEMORY.
- memory_write_enable  output  1  write strobe to MEMORY.
- memory_write_data  output  DATA_WIDTH  registered store data.
- memory_read_data  input  DATA_WIDTH  combinational read data from MEMORY.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; counter = 0; last_grant = FETCH.
  - All outputs 0: fetch_ready, data_ready, fetch_data, data_read_data, memory_enable, memory_address, memory_write_enable, memory_write_data.
  - Reset during ACCESS or DONE aborts the access: no ready pulse and no write.
- States:
  - IDLE:
    - No request: stay in IDLE.
    - Exactly one request: grant it.
    - Both requests: grant the requester not equal to last_grant (round-robin). After reset, data wins the first tie.
    - On grant: latch address, write data and write enable (forced 0 for fetch) into the memory_* registers; set memory_enable = 1; counter = MEM_LATENCY-1; last_grant = winner; next state = ACCESS.
  - ACCESS:
    - memory_address held stable.
    - memory_write_enable = 1 only in the final ACCESS cycle (counter == 0) of a store.
    - counter > 0: decrement.
    - counter == 0:
      - Read: capture memory_read_data into fetch_data or data_read_data (winner only).
      - Store: data_read_data unchanged.
      - memory_enable -> 0, memory_write_enable -> 0; next state = DONE.
  - DONE:
    - Winner's ready = 1 for exactly this cycle.
    - Requests are ignored; next state = IDLE.
- Latency: request sampled in IDLE at edge t. ACCESS occupies MEM_LATENCY cycles; ready is high in cycle t+MEM_LATENCY+1. Back-to-back throughput is one access per MEM_LATENCY+2 cycles.
- Handshake:
  - A requester holds its request and operands stable until its ready pulse.
  - The requester must deassert the request in the DONE cycle or it is re-arbitrated as a new access in IDLE.
  - Dropping a request mid-access does not cancel it; the access completes and ready still pulses.
- Non-winning request is never lost: it wins the next IDLE arbitration because last_grant alternates.
- fetch_data and data_read_data hold their last value until the next read for that requester.
- Never both ready outputs high in the same cycle; never two accesses in flight.

Test Plan (MEM_LATENCY=2, memory preloaded with word[i] = 0x1000+i, word addressing):
- Reset then fetch_request with fetch_address=0x10 at edge 1 -> memory_enable high 2 cycles, memory_address=0x10; fetch_ready pulses 1 cycle at cycle 4 with fetch_data=0x1010.
- Both requests asserted together after reset (fetch 0x4, data load 0x8) -> data served first (data_read_data=0x1008, data_ready); fetch served next (fetch_data=0x1004); one ready pulse per access, 4 cycles apart.
- Store data_address=0x20, data_write_data=0xDEADBEEF, then load 0x20 -> memory_write_enable high exactly 1 cycle with address 0x20; load returns 0xDEADBEEF; fetch_data unchanged.
- Both requests held continuously for 6 accesses -> grants alternate data, fetch, data, ...; neither starved; each ready pulse is a single cycle.
- Assert reset in the first ACCESS cycle of a store -> all outputs 0 immediately; no write reaches memory; no ready pulse; next request served normally.
- Fetch request dropped one cycle after grant -> access completes; fetch_ready still pulses; next IDLE shows no grant.
